fpu_chan_arbiter: RTL and testbench

//  Round-robin arbiter multiplexing NUM_CH independent request channels onto one FPNew-style
//  FPU port (valid/ready + tag); tags each issued op with its channel id and routes results back.

---
 rtl/fpu_chan_arbiter.sv | 133 +++++++++++++
 tb/tb_fpu_chan_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_chan_arbiter.sv
// fpu_chan_arbiter: round-robin mux of NUM_CH request channels onto one
// valid/ready FPU port. The granted channel index travels as the FPU tag,
// and returned results are steered back by that tag. Issue is throttled
// when MAX_OUT ops are in flight, and a flush is forwarded to the FPU.
module fpu_chan_arbiter #(
  parameter  int NUM_CH  = 4,
  parameter  int REQ_W   = 200,
  parameter  int RSP_W   = 69,
  parameter  int MAX_OUT = 8,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NUM_CH-1:0]            ch_in_valid_i,
  output logic [NUM_CH-1:0]            ch_in_ready_o,
  input  logic [NUM_CH-1:0][REQ_W-1:0] ch_req_i,
  output logic                         fpu_in_valid_o,
  input  logic                         fpu_in_ready_i,
  output logic [REQ_W-1:0]             fpu_req_o,
  output logic [CH_W-1:0]              fpu_tag_o,
  output logic                         fpu_flush_o,
  input  logic                         fpu_out_valid_i,
  output logic                         fpu_out_ready_o,
  input  logic [RSP_W-1:0]             fpu_rsp_i,
  input  logic [CH_W-1:0]              fpu_tag_i,
  output logic [NUM_CH-1:0]            ch_out_valid_o,
  input  logic [NUM_CH-1:0]            ch_out_ready_i,
  output logic [RSP_W-1:0]             ch_rsp_o,
  output logic [CNT_W-1:0]             outstanding_o,
  output logic                         busy_o,
  output logic                         tag_err_o
);

  logic [CH_W-1:0]   rr_ptr;
  logic              lock;
  logic [CH_W-1:0]   lock_idx;
  logic [CNT_W-1:0]  out_cnt;
  logic              tag_err;

  logic [CH_W-1:0]   rr_gnt;
  logic              rr_found;
  logic [CH_W-1:0]   scan_idx;
  logic [CH_W-1:0]   gnt;
  logic              en;
  logic              iss;
  logic              rsp_hs;
  logic [NUM_CH-1:0] tag_hit;
  logic              tag_ok;

  // Round-robin search: first valid channel strictly after rr_ptr, wrapping.
  always_comb begin
    rr_gnt   = rr_ptr;
    rr_found = 1'b0;
    scan_idx = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = (scan_idx == CH_W'(NUM_CH - 1)) ? '0 : scan_idx + CH_W'(1);
      if (!rr_found && ch_in_valid_i[scan_idx]) begin
        rr_found = 1'b1;
        rr_gnt   = scan_idx;
      end
    end
  end

  // A stalled offer keeps its channel so tag and payload stay stable.
  assign gnt            = lock ? lock_idx : rr_gnt;
  assign en             = !flush_i && (out_cnt < CNT_W'(MAX_OUT));
  assign fpu_in_valid_o = en && (lock || rr_found);
  assign fpu_req_o      = ch_req_i[gnt];
  assign fpu_tag_o      = gnt;
  assign fpu_flush_o    = flush_i;
  assign iss            = fpu_in_valid_o && fpu_in_ready_i;

  // Per-channel issue-ready and result-tag decode.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_in_ready_o[k] = iss && (gnt == CH_W'(k));
    assign tag_hit[k]       = (fpu_tag_i == CH_W'(k));
  end

  // Out-of-range tags are swallowed so the FPU never blocks on them; a flush
  // also drains whatever result is presented.
  assign tag_ok          = |tag_hit;
  assign ch_out_valid_o  = tag_hit & {NUM_CH{fpu_out_valid_i && !flush_i}};
  assign fpu_out_ready_o = flush_i || !tag_ok || |(tag_hit & ch_out_ready_i);
  assign ch_rsp_o        = fpu_rsp_i;
  assign rsp_hs          = fpu_out_valid_i && fpu_out_ready_o;

  assign outstanding_o = out_cnt;
  assign busy_o        = (out_cnt != '0) || fpu_in_valid_o;
  assign tag_err_o     = tag_err;

  // Grant lock: captured on a stalled offer, released on handshake or flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (flush_i || iss) begin
      lock     <= 1'b0;
    end else if (fpu_in_valid_o) begin
      lock     <= 1'b1;
      lock_idx <= gnt;
    end
  end

  // Round-robin pointer advances to the last issued channel; kept across flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  rr_ptr <= CH_W'(NUM_CH - 1);
    else if (iss) rr_ptr <= gnt;
  end

  // In-flight counter: issue adds, result handshake removes, floor at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt <= '0;
    end else if (flush_i) begin
      out_cnt <= '0;
    end else begin
      case ({iss, rsp_hs})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   if (out_cnt != '0) out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Sticky bad-tag flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         tag_err <= 1'b0;
    else if (fpu_out_valid_i && !tag_ok) tag_err <= 1'b1;
  end

endmodule

// File: tb/tb_fpu_chan_arbiter.sv
// tb_fpu_chan_arbiter: directed scenarios plus randomized traffic, each cycle
// checked against a transaction-level reference model of the arbiter.
module tb_fpu_chan_arbiter;
  localparam int NUM_CH  = 3;
  localparam int REQ_W   = 16;
  localparam int RSP_W   = 8;
  localparam int MAX_OUT = 4;
  localparam int CH_W    = 2;
  localparam int CNT_W   = 3;

  logic                         clk_i = 1'b0;
  logic                         rst_ni = 1'b0;
  logic                         flush_i = 1'b0;
  logic [NUM_CH-1:0]            ch_in_valid_i = '0;
  logic [NUM_CH-1:0]            ch_in_ready_o;
  logic [NUM_CH-1:0][REQ_W-1:0] ch_req_i = '0;
  logic                         fpu_in_valid_o;
  logic                         fpu_in_ready_i = 1'b0;
  logic [REQ_W-1:0]             fpu_req_o;
  logic [CH_W-1:0]              fpu_tag_o;
  logic                         fpu_flush_o;
  logic                         fpu_out_valid_i = 1'b0;
  logic                         fpu_out_ready_o;
  logic [RSP_W-1:0]             fpu_rsp_i = '0;
  logic [CH_W-1:0]              fpu_tag_i = '0;
  logic [NUM_CH-1:0]            ch_out_valid_o;
  logic [NUM_CH-1:0]            ch_out_ready_i = '0;
  logic [RSP_W-1:0]             ch_rsp_o;
  logic [CNT_W-1:0]             outstanding_o;
  logic                         busy_o;
  logic                         tag_err_o;

  fpu_chan_arbiter #(.NUM_CH(NUM_CH), .REQ_W(REQ_W), .RSP_W(RSP_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .ch_in_valid_i(ch_in_valid_i), .ch_in_ready_o(ch_in_ready_o), .ch_req_i(ch_req_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_req_o(fpu_req_o), .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_rsp_i(fpu_rsp_i), .fpu_tag_i(fpu_tag_i),
    .ch_out_valid_o(ch_out_valid_o), .ch_out_ready_i(ch_out_ready_i), .ch_rsp_o(ch_rsp_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .tag_err_o(tag_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_last;            // channel that issued most recently
  bit m_held;            // an offer was refused and must be repeated
  int m_held_ch;
  int m_inflight;
  bit m_bad_tag;
  logic [NUM_CH-1:0] accepted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last = NUM_CH - 1; m_held = 0; m_held_ch = 0; m_inflight = 0; m_bad_tag = 0;
  endtask

  // Inputs are set just after a negedge; check outputs, advance the model
  // across the next posedge, and return at the following negedge.
  task automatic step(input string tag);
    int g; bit fnd; bit ev; bit good; bit e_ordy; bit iss; bit rsp; int c;
    logic [NUM_CH-1:0] e_rdy, e_ov;
    #1;
    fnd = 0; g = 0;
    if (m_held) begin g = m_held_ch; fnd = 1; end
    else for (int i = 1; i <= NUM_CH; i++) begin
      c = (m_last + i) % NUM_CH;
      if (!fnd && ch_in_valid_i[c]) begin fnd = 1; g = c; end
    end
    ev = !flush_i && (m_inflight < MAX_OUT) && fnd;
    e_rdy = '0;
    if (ev && fpu_in_ready_i) e_rdy[g] = 1'b1;
    good = (int'(fpu_tag_i) < NUM_CH);
    e_ov = '0;
    if (fpu_out_valid_i && !flush_i && good) e_ov[fpu_tag_i] = 1'b1;
    e_ordy = flush_i || !good || (good && ch_out_ready_i[fpu_tag_i]);

    chk({tag, ".in_valid"}, 32'(fpu_in_valid_o), 32'(ev));
    if (ev) begin
      chk({tag, ".tag"}, 32'(fpu_tag_o), 32'(g));
      chk({tag, ".req"}, 32'(fpu_req_o), 32'(ch_req_i[g]));
    end
    chk({tag, ".in_ready"},  32'(ch_in_ready_o),   32'(e_rdy));
    chk({tag, ".out_valid"}, 32'(ch_out_valid_o),  32'(e_ov));
    chk({tag, ".out_ready"}, 32'(fpu_out_ready_o), 32'(e_ordy));
    chk({tag, ".rsp"},       32'(ch_rsp_o),        32'(fpu_rsp_i));
    chk({tag, ".flush"},     32'(fpu_flush_o),     32'(flush_i));
    chk({tag, ".count"},     32'(outstanding_o),   32'(m_inflight));
    chk({tag, ".busy"},      32'(busy_o),          32'((m_inflight != 0) || ev));
    chk({tag, ".tag_err"},   32'(tag_err_o),       32'(m_bad_tag));

    iss = ev && fpu_in_ready_i;
    rsp = fpu_out_valid_i && e_ordy;
    if (flush_i) begin
      m_inflight = 0; m_held = 0;
    end else begin
      if (iss && !rsp) m_inflight++;
      else if (!iss && rsp && m_inflight > 0) m_inflight--;
      if (iss) m_held = 0;
      else if (ev) begin m_held = 1; m_held_ch = g; end
    end
    if (iss) m_last = g;
    if (fpu_out_valid_i && !good) m_bad_tag = 1;
    accepted = e_rdy;
    @(negedge clk_i);
  endtask

  // Channels keep valid+payload until accepted, then optionally present new work.
  task automatic refill(input int pct);
    for (int k = 0; k < NUM_CH; k++) begin
      if (accepted[k] || !ch_in_valid_i[k]) begin
        ch_in_valid_i[k] = ($urandom_range(0, 99) < pct);
        ch_req_i[k] = REQ_W'($urandom);
      end
    end
  endtask

  initial begin
    model_reset();
    accepted = '0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset.count",     32'(outstanding_o),   0);
    chk("reset.tag_err",   32'(tag_err_o),       0);
    chk("reset.in_valid",  32'(fpu_in_valid_o),  0);
    chk("reset.in_ready",  32'(ch_in_ready_o),   0);
    chk("reset.out_valid", 32'(ch_out_valid_o),  0);
    chk("reset.busy",      32'(busy_o),          0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // all channels valid, FPU always ready: tags rotate 0,1,2,0 then throttle
    ch_in_valid_i = '1;
    for (int k = 0; k < NUM_CH; k++) ch_req_i[k] = REQ_W'(16'hA000 + k);
    fpu_in_ready_i = 1'b1;
    for (int n = 0; n < 6; n++) step("rr");
    chk("rr.full_count", 32'(outstanding_o), MAX_OUT);

    // flush with a result pending drains everything
    flush_i = 1'b1; fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd1; ch_out_ready_i = '0;
    step("flush");
    flush_i = 1'b0; fpu_out_valid_i = 1'b0; ch_in_valid_i = '0; fpu_in_ready_i = 1'b0;
    step("post_flush");
    chk("post_flush.count", 32'(outstanding_o), 0);

    // stalled ch2 offer must hold while ch0 rises
    ch_in_valid_i = 3'b100; ch_req_i[2] = REQ_W'(16'h2222);
    step("stall0");
    ch_in_valid_i = 3'b101; ch_req_i[0] = REQ_W'(16'h0000);
    step("stall1");
    step("stall2");
    fpu_in_ready_i = 1'b1;
    step("stall_acc");
    ch_in_valid_i = 3'b001;
    step("stall_next");
    ch_in_valid_i = '0;

    // result held while the channel is not ready, then taken
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd1; fpu_rsp_i = 8'h5A; ch_out_ready_i = '0;
    step("rsp_hold");
    step("rsp_hold2");
    ch_out_ready_i = 3'b010;
    step("rsp_take");
    // out-of-range tag is dropped and flagged
    fpu_tag_i = 2'd3;
    step("bad_tag");
    fpu_out_valid_i = 1'b0;
    step("bad_tag_sticky");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      refill(60);
      fpu_in_ready_i  = ($urandom_range(0, 99) < 70);
      fpu_out_valid_i = ($urandom_range(0, 99) < 35);
      fpu_tag_i       = ($urandom_range(0, 99) < 5) ? 2'd3 : CH_W'($urandom_range(0, NUM_CH - 1));
      fpu_rsp_i       = RSP_W'($urandom);
      ch_out_ready_i  = NUM_CH'($urandom);
      flush_i         = ($urandom_range(0, 99) < 3);
      step("rand");
    end

    // asynchronous reset in the middle of traffic
    flush_i = 1'b0; fpu_out_valid_i = 1'b0; fpu_in_ready_i = 1'b1; ch_in_valid_i = '1;
    step("pre_rst");
    step("pre_rst");
    #2;
    rst_ni = 1'b0;
    ch_in_valid_i = '0; fpu_in_ready_i = 1'b0;
    #1;
    chk("arst.count",   32'(outstanding_o), 0);
    chk("arst.tag_err", 32'(tag_err_o),     0);
    chk("arst.busy",    32'(busy_o),        0);
    model_reset();
    accepted = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    ch_in_valid_i = 3'b010; fpu_in_ready_i = 1'b1;
    step("after_rst");
    step("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
